// File: rtl/alt_pfl_crc_pkg.sv
// ============================================================================
// alt_pfl_crc_pkg : shared CRC-16/XMODEM constants, FSM states, byte update
// Revision 1.0
// ============================================================================
`default_nettype none

package alt_pfl_crc_pkg;

    localparam int             CRC_W    = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        CRC_RX = 3'd2,
        CMP    = 3'd3,
        DONE   = 3'd4
    } crc_state_t;

    // Bitwise unrolling of crc_next = (crc<<8) ^ T[(crc>>8) ^ d]; same result as the table form.
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [7:0]       d);
        logic [CRC_W-1:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[CRC_W-1] ? ({c[CRC_W-2:0], 1'b0} ^ CRC_POLY) : {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alt_pfl_crc_byte_update.sv
// ============================================================================
// alt_pfl_crc_byte_update : combinational next-CRC for one data byte
// Revision 1.0
// ============================================================================
`default_nettype none

module alt_pfl_crc_byte_update
    import alt_pfl_crc_pkg::*;
(
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       d_i,
    output logic [CRC_W-1:0] crc_o
);

    assign crc_o = crc16_byte(crc_i, d_i);

endmodule

`default_nettype wire

// File: rtl/alt_pfl_crc_check.sv
// ============================================================================
// alt_pfl_crc_check : receive-side CRC-16/XMODEM checker with serial CRC compare.
// Optional error counter output err_cnt enabled by ALT_PFL_CRC_CHECK_ERRCNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module alt_pfl_crc_check
    import alt_pfl_crc_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [7:0]       d,
    input  logic             d_valid,
    input  logic             d_last,
    output logic             d_ready,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             timeout,
    output logic [CRC_W-1:0] crc_value,
    output logic [LEN_W-1:0] byte_cnt
`ifdef ALT_PFL_CRC_CHECK_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    crc_state_t       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] rx_q, rx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic [CRC_W-1:0] crc_upd;
    logic             ready_w;
    logic             done_w;

    alt_pfl_crc_byte_update u_byte_update (
        .crc_i (crc_q),
        .d_i   (d),
        .crc_o (crc_upd)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            rx_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            idle_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idle_q  <= idle_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idle_d  = idle_q;
        ok_d    = ok_q;
        err_d   = err_q;
        to_d    = to_q;
        ready_w = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    crc_d   = CRC_INIT;
                    rx_d    = '0;
                    cnt_d   = '0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            DATA: begin
                ready_w = 1'b1;
                if (d_valid) begin
                    crc_d = crc_upd;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                    if (d_last) begin
                        state_d = CRC_RX;
                        bit_d   = '0;
                        idle_d  = '0;
                    end
                end
            end
            CRC_RX: begin
                // First bit received walks down to bit 0 after 16 right shifts.
                if (sin_valid) begin
                    rx_d   = {sin, rx_q[CRC_W-1:1]};
                    bit_d  = bit_q + 5'd1;
                    idle_d = '0;
                    if (bit_q == 5'd15) begin
                        state_d = CMP;
                    end
                end else if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            CMP: begin
                ok_d    = (rx_q == crc_q);
                err_d   = (rx_q != crc_q);
                state_d = DONE;
            end
            DONE: begin
                done_w  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALT_PFL_CRC_CHECK_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            errcnt_q <= 8'h00;
        end else if (state_q == DONE && err_q && errcnt_q != 8'hFF) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign err_cnt = errcnt_q;
`endif

    assign d_ready   = ready_w;
    assign done      = done_w;
    assign busy      = (state_q != IDLE);
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign timeout   = to_q;
    assign crc_value = crc_q;
    assign byte_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alt_pfl_crc_check.sv
// ============================================================================
// tb_alt_pfl_crc_check : scoreboard bench for alt_pfl_crc_check
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alt_pfl_crc_check;

    localparam int LEN_W       = 16;
    localparam int TIMEOUT_CYC = 1024;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       d = 8'h00;
    logic             d_valid = 1'b0;
    logic             d_last = 1'b0;
    logic             d_ready;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic             timeout;
    logic [15:0]      crc_value;
    logic [LEN_W-1:0] byte_cnt;
`ifdef ALT_PFL_CRC_CHECK_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    alt_pfl_crc_check #(.LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .d         (d),
        .d_valid   (d_valid),
        .d_last    (d_last),
        .d_ready   (d_ready),
        .sin       (sin),
        .sin_valid (sin_valid),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .timeout   (timeout),
        .crc_value (crc_value),
        .byte_cnt  (byte_cnt)
`ifdef ALT_PFL_CRC_CHECK_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic        err;
        logic        to;
        logic [15:0] crc;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_bad  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one bit at a time, MSB first.
    function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (msg[k]) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ msg[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("crc_ok",    {31'd0, crc_ok},  {31'd0, e.ok});
                check("crc_err",   {31'd0, crc_err}, {31'd0, e.err});
                check("timeout",   {31'd0, timeout}, {31'd0, e.to});
                check("crc_value", {16'd0, crc_value}, {16'd0, e.crc});
                check("byte_cnt",  {16'd0, byte_cnt},  {16'd0, e.cnt});
                if (e.err) n_bad++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        d       = b;
        d_valid = 1'b1;
        d_last  = last;
        tick();
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int lo, input int hi, input bit gap);
        for (int i = lo; i < hi; i++) begin
            if (gap) tick();
            sin       = v[i];
            sin_valid = 1'b1;
            tick();
            sin_valid = 1'b0;
        end
    endtask

    task automatic send_data(input logic [7:0] msg[$], input bit gap);
        foreach (msg[k]) begin
            if (gap) begin
                d_valid = 1'b0;
                tick();
                check("dready_data", {31'd0, d_ready}, 32'd1);
            end
            send_byte(msg[k], k == msg.size() - 1);
        end
        check("dready_rx", {31'd0, d_ready}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] msg[$], input logic [15:0] rx, input bit gap);
        exp_t        e;
        logic [15:0] c;
        c     = ref_crc(msg);
        e.ok  = (rx == c);
        e.err = (rx != c);
        e.to  = 1'b0;
        e.crc = c;
        e.cnt = 16'(msg.size());
        sb_q.push_back(e);
        pulse_start();
        send_data(msg, gap);
        send_bits(rx, 0, 16, gap);
    endtask

    logic [7:0]  s123[$];
    logic [7:0]  msg[$];
    logic [15:0] c;
    exp_t        e;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, d_ready}, 32'd0);
        check("rst_flags", {29'd0, crc_ok, crc_err, timeout}, 32'd0);
        check("rst_crc",   {16'd0, crc_value}, 32'd0);
        check("rst_cnt",   {16'd0, byte_cnt}, 32'd0);
        clr = 1'b0;
        tick();

        // Good frame, with done latency checked against the 16th bit edge.
        e = '{ok: 1'b1, err: 1'b0, to: 1'b0, crc: 16'h31C3, cnt: 16'd9};
        sb_q.push_back(e);
        pulse_start();
        send_data(s123, 1'b0);
        send_bits(16'h31C3, 0, 16, 1'b0);
        check("done_lat1", {31'd0, done}, 32'd0);
        tick();
        check("done_lat2", {31'd0, done}, 32'd1);
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_busy",  {31'd0, busy}, 32'd0);
        check("hold_crc",   {16'd0, crc_value}, 32'h31C3);
        check("hold_ok",    {31'd0, crc_ok}, 32'd1);

        run_frame(s123, 16'h31C2, 1'b0);
        repeat (2) tick();

        check("idle_ready", {31'd0, d_ready}, 32'd0);
        msg = '{8'h01};
        run_frame(msg, 16'h1021, 1'b1);
        repeat (2) tick();
        check("one_byte_crc", {16'd0, crc_value}, 32'h1021);

        // Serial stage stalls after 8 bits.
        msg   = '{8'hA5, 8'h5A, 8'h00};
        e.ok  = 1'b0;
        e.err = 1'b1;
        e.to  = 1'b1;
        e.crc = ref_crc(msg);
        e.cnt = 16'd3;
        sb_q.push_back(e);
        pulse_start();
        send_data(msg, 1'b0);
        send_bits(16'hFFFF, 0, 8, 1'b0);
        n = 0;
        for (int i = 1; i <= TIMEOUT_CYC + 50; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
        check("timeout_lat", n, TIMEOUT_CYC);
        tick();
        check("timeout_idle", {31'd0, busy}, 32'd0);
        check("timeout_hold", {30'd0, crc_err, timeout}, 32'd3);

        // Async clear in the middle of the data stage.
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(s123[k], 1'b0);
        #2;
        clr = 1'b1;
        #1;
        check("clr_busy",  {31'd0, busy}, 32'd0);
        check("clr_ready", {31'd0, d_ready}, 32'd0);
        check("clr_crc",   {16'd0, crc_value}, 32'd0);
        check("clr_cnt",   {16'd0, byte_cnt}, 32'd0);
        check("clr_flags", {29'd0, crc_ok, crc_err, timeout}, 32'd0);
        n_bad = 0;
        tick();
        clr = 1'b0;
        tick();

        // Fresh frame with a stray start inside the serial stage.
        e = '{ok: 1'b1, err: 1'b0, to: 1'b0, crc: 16'h31C3, cnt: 16'd9};
        sb_q.push_back(e);
        pulse_start();
        send_data(s123, 1'b0);
        send_bits(16'h31C3, 0, 8, 1'b0);
        pulse_start();
        check("stray_busy", {31'd0, busy}, 32'd1);
        check("stray_cnt",  {16'd0, byte_cnt}, 32'd9);
        send_bits(16'h31C3, 8, 16, 1'b0);
        repeat (2) tick();

        for (int r = 0; r < 6; r++) begin
            msg = {};
            for (int k = 0; k < $urandom_range(1, 6); k++) msg.push_back(8'($urandom));
            c = ref_crc(msg);
            if (r % 2 == 1) c = c ^ (16'h0001 << $urandom_range(0, 15));
            run_frame(msg, c, r[1]);
            repeat (2) tick();
        end

`ifdef ALT_PFL_CRC_CHECK_ERRCNT_EN
        check("errcnt", {24'd0, err_cnt}, n_bad);
        pulse_start();
        check("errcnt_start", {24'd0, err_cnt}, n_bad);
        clr = 1'b1;
        #1;
        check("errcnt_clr", {24'd0, err_cnt}, 32'd0);
        tick();
        clr = 1'b0;
        tick();
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
